box_renderer: RTL and testbench

BOX_RENDERER -- requirements
Module: box_renderer

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/btn_debounce.sv | 54 +++++
 rtl/box_renderer.sv | 98 +++++++++
 tb/tb_box_renderer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel colour type and the box bounce step helper.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam logic [9:0] BOX_X0 = 10'd304;
    localparam logic [9:0] BOX_Y0 = 10'd224;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;
    localparam rgb_t RGB_BG    = rgb_t'(6'b010101);

    // Indexed by speed-1: element 0 is speed 1.
    localparam rgb_t [3:0] SPEED_PALETTE = {
        rgb_t'(6'b111111),
        rgb_t'(6'b000011),
        rgb_t'(6'b001100),
        rgb_t'(6'b110000)
    };

    // Returns {new_dir, new_pos}; clamps at the limit/zero and reverses there.
    function automatic logic [10:0] step_axis(input logic [9:0] pos,
                                              input logic       dir,
                                              input logic [2:0] speed,
                                              input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + {8'b0, speed};
        if (dir) begin
            if (sum >= {1'b0, lim}) return {1'b0, lim};
            else                    return {1'b1, sum[9:0]};
        end else begin
            if (pos <= {7'b0, speed}) return {1'b1, 10'd0};
            else                      return {1'b0, pos - {7'b0, speed}};
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on a debounced press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    localparam logic [DEBOUNCE_W-1:0] CNT_LAST =
        DEBOUNCE_W'((64'd1 << DEBOUNCE_W) - 64'd2);

    logic                  sync1_q, sync2_q;
    logic                  level_q, level_d;
    logic                  press_q, press_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  differ, settle;

    // settle marks the last of 2^W-1 consecutive differing cycles.
    always_comb begin
        differ  = (sync2_q != level_q);
        settle  = differ && (cnt_q == CNT_LAST);
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (differ && !settle) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (settle) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/box_renderer.sv
// Bouncing box over a checkerboard; button cycles box speed/colour, output registered one cycle.
module box_renderer
    import vga_pkg::*;
#(
    parameter int unsigned DEBOUNCE_W = 16,
    parameter int unsigned BOX_SIZE   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic       btn_n,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       hs_o,
    output logic       vs_o
);

    localparam logic [9:0]  X_LIM  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  Y_LIM  = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] BOX_M1 = 11'(BOX_SIZE - 1);

    logic [9:0] bx_q, bx_d, by_q, by_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [2:0] speed_q, speed_d;
    rgb_t       rgb_q, rgb_d;
    logic       hs_q, vs_q;
    logic       press, tick, active, hit;

    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n_i(btn_n),
        .press_o(press)
    );

    assign tick = (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1));

    // Position steps with speed_q, so a coincident press only affects later ticks.
    always_comb begin
        bx_d    = bx_q;
        by_d    = by_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        speed_d = speed_q;
        if (tick) begin
            {dir_x_d, bx_d} = step_axis(bx_q, dir_x_q, speed_q, X_LIM);
            {dir_y_d, by_d} = step_axis(by_q, dir_y_q, speed_q, Y_LIM);
        end
        if (press) begin
            speed_d = (speed_q == 3'd4) ? 3'd1 : speed_q + 3'd1;
        end
    end

    always_comb begin
        active = (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
        hit    = ({1'b0, x} >= {1'b0, bx_q}) && ({1'b0, x} <= {1'b0, bx_q} + BOX_M1) &&
                 ({1'b0, y} >= {1'b0, by_q}) && ({1'b0, y} <= {1'b0, by_q} + BOX_M1);
        rgb_d  = RGB_BLACK;
        if (active) begin
            if (hit)              rgb_d = SPEED_PALETTE[2'(speed_q - 3'd1)];
            else if (x[4] ^ y[4]) rgb_d = RGB_BLACK;
            else                  rgb_d = RGB_BG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bx_q    <= BOX_X0;
            by_q    <= BOX_Y0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            speed_q <= 3'd1;
            rgb_q   <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            bx_q    <= bx_d;
            by_q    <= by_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            speed_q <= speed_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_i;
            vs_q    <= vs_i;
        end
    end

    assign r    = rgb_q.r;
    assign g    = rgb_q.g;
    assign b    = rgb_q.b;
    assign hs_o = hs_q;
    assign vs_o = vs_q;

endmodule

// File: tb/tb_box_renderer.sv
// Scoreboard bench for box_renderer: probes push expected {rgb,hs,vs}; a monitor pops and compares.
module tb_box_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       hs_i, vs_i, btn_n;
    logic [1:0] r, g, b;
    logic       hs_o, vs_o;

    logic       probe_now = 1'b0;
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         passed = 0;

    logic [7:0] mon_exp, mon_act;
    string      mon_nm;

    localparam logic [5:0] C1 = 6'b110000;
    localparam logic [5:0] C2 = 6'b001100;
    localparam logic [5:0] C3 = 6'b000011;
    localparam logic [5:0] C4 = 6'b111111;
    localparam logic [5:0] BG = 6'b010101;
    localparam logic [5:0] BK = 6'b000000;

    always #5 clk = ~clk;

    box_renderer #(.DEBOUNCE_W(4), .BOX_SIZE(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (x),
        .y    (y),
        .hs_i (hs_i),
        .vs_i (vs_i),
        .btn_n(btn_n),
        .r    (r),
        .g    (g),
        .b    (b),
        .hs_o (hs_o),
        .vs_o (vs_o)
    );

    task automatic probe(input string nm, input int px, input int py,
                         input logic h, input logic v, input logic [7:0] expv);
        @(negedge clk);
        x = 10'(px); y = 10'(py); hs_i = h; vs_i = v; probe_now = 1'b1;
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    task automatic pix(input string nm, input int px, input int py, input logic [5:0] rgb);
        probe(nm, px, py, 1'b0, 1'b0, {rgb, 2'b00});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            x = '0; y = '0; hs_i = 1'b0; vs_i = 1'b0; probe_now = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            x = 10'd639; y = 10'd479; probe_now = 1'b0;
            @(negedge clk);
            x = '0; y = '0;
        end
    endtask

    task automatic btn_hold(input logic lvl, input int n);
        btn_n = lvl;
        idle(n);
    endtask

    always @(posedge clk) begin
        if (probe_now) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: output presented with no expectation queued");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                mon_act = {r, g, b, hs_o, vs_o};
                if (mon_act === mon_exp) passed++;
                else $display("FAIL %s: got %b expected %b ({r,g,b,hs,vs})", mon_nm, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  waited;
        logic seen;
        rst_n = 1'b0; btn_n = 1'b1;
        x = '0; y = '0; hs_i = 1'b0; vs_i = 1'b0;
        idle(2);
        probe("reset_outputs", 304, 224, 1'b1, 1'b1, 8'b0);
        @(negedge clk);
        rst_n = 1'b1; probe_now = 1'b0; x = '0; y = '0; hs_i = 1'b0; vs_i = 1'b0;

        // Initial box at (304,224), speed 1
        probe("box_origin_hs", 304, 224, 1'b1, 1'b0, {C1, 2'b10});
        probe("left_of_box_vs", 303, 224, 1'b0, 1'b1, {BG, 2'b01});
        probe("outside_x700", 700, 224, 1'b1, 1'b1, {BK, 2'b11});
        pix("box_far_corner", 335, 255, C1);
        pix("right_of_box", 336, 224, BK);
        pix("x640_blank", 640, 0, BK);
        pix("y480_blank", 16, 480, BK);
        pix("last_row_bg", 16, 479, BG);

        tick(3);
        pix("three_ticks_box", 307, 227, C1);
        pix("three_ticks_left", 306, 227, BK);
        idle(10);
        pix("no_tick_hold", 307, 227, C1);
        pix("no_tick_corner", 338, 258, C1);

        // Right-edge bounce
        tick(300);
        pix("bx607_box", 607, 369, C1);
        pix("bx607_left", 606, 369, BG);
        tick(1);
        pix("bx608_box", 608, 368, C1);
        pix("bx608_left", 607, 368, BG);
        tick(1);
        pix("bx607_back", 607, 367, C1);
        pix("bx607_right_edge", 638, 367, C1);
        pix("bx607_past_edge", 639, 367, BK);

        // Left-edge bounce
        tick(606);
        pix("bx1_box", 1, 239, C1);
        pix("bx1_left", 0, 239, BG);
        tick(1);
        pix("bx0_box", 0, 240, C1);
        tick(1);
        pix("bx1_again", 1, 241, C1);
        pix("bx1_again_left", 0, 241, BK);

        // Glitches then a real press
        btn_hold(1'b0, 3); btn_hold(1'b1, 3);
        btn_hold(1'b0, 3); btn_hold(1'b1, 3);
        pix("glitch_no_press", 1, 241, C1);
        btn_hold(1'b0, 20);
        pix("press1_speed2", 1, 241, C2);
        btn_hold(1'b1, 20);
        pix("release_no_change", 1, 241, C2);
        btn_hold(1'b0, 20); btn_hold(1'b1, 20);
        pix("press2_speed3", 1, 241, C3);
        btn_hold(1'b0, 20); btn_hold(1'b1, 20);
        pix("press3_speed4", 1, 241, C4);
        btn_hold(1'b0, 20); btn_hold(1'b1, 20);
        pix("press4_wrap1", 1, 241, C1);

        // Press pulse coincident with a tick
        btn_n = 1'b0;
        waited = 0; seen = 1'b0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            probe_now = 1'b0;
            if (dut.u_deb.press_o) begin
                seen = 1'b1; x = 10'd639; y = 10'd479;
            end else begin
                x = '0; y = '0;
            end
            waited++;
        end
        checks++;
        if (seen) passed++;
        else $display("FAIL press_pulse_seen: got none within %0d cycles, required one", waited);
        idle(1);
        btn_hold(1'b1, 20);
        pix("coincident_step1", 2, 242, C2);
        pix("coincident_left", 1, 242, BK);
        tick(1);
        pix("next_tick_step2", 4, 244, C2);
        pix("next_tick_left", 3, 244, BK);

        // Reset mid-debounce with button held low
        btn_hold(1'b0, 8);
        @(negedge clk);
        rst_n = 1'b0;
        idle(3);
        probe("reset_mid_run", 4, 244, 1'b1, 1'b1, 8'b0);
        @(negedge clk);
        rst_n = 1'b1; probe_now = 1'b0; x = '0; y = '0; hs_i = 1'b0; vs_i = 1'b0;
        for (int i = 0; i < 15; i++) pix("post_reset_no_press", 304, 224, C1);
        pix("post_reset_left", 303, 224, BG);
        idle(30);
        pix("one_press_after_reset", 304, 224, C2);
        idle(30);
        pix("held_no_repeat", 304, 224, C2);
        btn_hold(1'b1, 20);
        tick(1);
        pix("reset_dirs_box", 306, 226, C2);
        pix("reset_dirs_left", 305, 226, BK);

        idle(3);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
